usb_report_transmitter: RTL

USB_REPORT_TRANSMITTER -- requirements
Module: usb_report_transmitter

---
 rtl/usb_report_transmitter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/usb_report_transmitter.sv
// Sends a panel-switch report to an external USB FIFO, one byte per nibble.
// Optional macro USB_TX_CHECKSUM_EN appends a fifth byte carrying the nibble XOR.
module usb_report_transmitter #(
  parameter int SETUP_CYCLES    = 2,
  parameter int WR_PULSE_CYCLES = 4,
  parameter int RECOVER_CYCLES  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        txe_n,
  input  logic        bus_grant,
  input  logic        report_request,
  input  logic [15:0] panel_switches,
  output logic [7:0]  data_out,
  output logic        wr_n,
  output logic        data_out_enable,
  output logic        busy,
  output logic        done
);

  // state    | meaning
  // IDLE     | no report running; waits for a granted request
  // WAIT_TXE | waits for the FIFO to accept a byte
  // SETUP    | data driven, wr_n still high
  // STROBE   | wr_n low
  // HOLD     | wr_n back high, data still driven
  // RECOVER  | bus released, lets txe_n settle before next byte
  // DONE     | one-cycle done pulse
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_TXE = 3'd1;
  localparam logic [2:0] SETUP    = 3'd2;
  localparam logic [2:0] STROBE   = 3'd3;
  localparam logic [2:0] HOLD     = 3'd4;
  localparam logic [2:0] RECOVER  = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

`ifdef USB_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  logic [2:0]  state;
  logic [2:0]  idx;
  logic [3:0]  cnt;
  logic [15:0] snap;
  logic        pending;
  logic [3:0]  nibble;
  logic [3:0]  tag;
  logic [7:0]  next_byte;

  always_comb begin
    nibble = 4'h0;
    case (idx)
      3'd0: nibble = snap[3:0];
      3'd1: nibble = snap[7:4];
      3'd2: nibble = snap[11:8];
      3'd3: nibble = snap[15:12];
`ifdef USB_TX_CHECKSUM_EN
      3'd4: nibble = snap[3:0] ^ snap[7:4] ^ snap[11:8] ^ snap[15:12];
`endif
      default: nibble = 4'h0;
    endcase
    tag       = {1'b0, idx} + 4'd1;
    next_byte = {tag, nibble};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      idx             <= 3'd0;
      cnt             <= 4'd0;
      snap            <= 16'h0000;
      pending         <= 1'b0;
      data_out        <= 8'h00;
      wr_n            <= 1'b1;
      data_out_enable <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      // Requests arriving mid-report (including in DONE) merge into one pending slot.
      if (report_request && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: begin
          if ((report_request || pending) && bus_grant) begin
            snap    <= panel_switches;
            idx     <= 3'd0;
            busy    <= 1'b1;
            pending <= 1'b0;
            state   <= WAIT_TXE;
          end else if (report_request) begin
            pending <= 1'b1;
            busy    <= 1'b1;
          end
        end
        WAIT_TXE: begin
          if (!txe_n) begin
            data_out        <= next_byte;
            data_out_enable <= 1'b1;
            cnt             <= 4'(SETUP_CYCLES - 1);
            state           <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            wr_n  <= 1'b0;
            cnt   <= 4'(WR_PULSE_CYCLES - 1);
            state <= STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            wr_n  <= 1'b1;
            state <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          data_out_enable <= 1'b0;
          cnt             <= 4'(RECOVER_CYCLES - 1);
          state           <= RECOVER;
        end
        RECOVER: begin
          if (cnt == 4'd0) begin
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= WAIT_TXE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          busy  <= pending || report_request;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
